// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack handshake and
// loads IR/PC_1 for the decoder, with a one-entry skid buffer and branch redirect/drain.
`timescale 1ns/1ps
module instruction_fetch #(
   parameter int unsigned         PC_WIDTH  = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
   parameter logic [31:0]         NOP_INSTR = 32'h0000_0000
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                STALL,
   input  logic                REDIRECT,
   input  logic [PC_WIDTH-1:0] REDIRECT_PC,
   output logic                IMEM_REQ,
   output logic [PC_WIDTH-1:0] IMEM_ADDR,
   input  logic                IMEM_ACK,
   input  logic [31:0]         IMEM_RDATA,
   output logic [31:0]         IR,
   output logic [PC_WIDTH-1:0] PC_1,
   output logic                IR_VALID
);

   typedef enum logic [1:0] {S_REQ, S_HOLD, S_DRAIN} state_e;

   state_e              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [PC_WIDTH-1:0] pc1_q, pc1_d;
   logic [PC_WIDTH-1:0] hpc1_q, hpc1_d;
   logic [PC_WIDTH-1:0] daddr_q, daddr_d;
   logic [31:0]         ir_q, ir_d;
   logic [31:0]         hbuf_q, hbuf_d;
   logic                ir_valid_q, ir_valid_d;
   logic                ack;
   logic [PC_WIDTH-1:0] pc_inc;

   // DRAIN keeps presenting the address of the abandoned read until memory answers it.
   assign IMEM_REQ  = (state_q != S_HOLD);
   assign IMEM_ADDR = (state_q == S_DRAIN) ? daddr_q : pc_q;
   assign ack       = IMEM_REQ & IMEM_ACK;
   assign pc_inc    = pc_q + PC_WIDTH'(1);

   assign IR       = ir_q;
   assign PC_1     = pc1_q;
   assign IR_VALID = ir_valid_q;

   always_comb begin
      // NOTE: every _d defaults to its _q first, so no path leaves a signal unassigned (no latches).
      state_d    = state_q;
      pc_d       = pc_q;
      pc1_d      = pc1_q;
      hpc1_d     = hpc1_q;
      daddr_d    = daddr_q;
      ir_d       = ir_q;
      hbuf_d     = hbuf_q;
      ir_valid_d = ir_valid_q;

      if (REDIRECT) begin
         ir_d       = NOP_INSTR;
         ir_valid_d = 1'b0;
         pc_d       = REDIRECT_PC;
         if (state_q == S_REQ && !ack) begin
            state_d = S_DRAIN;
            daddr_d = pc_q;
         end else if (state_q == S_DRAIN && !ack) begin
            state_d = S_DRAIN;
         end else begin
            state_d = S_REQ;
         end
      end else begin
         unique case (state_q)
            S_REQ: begin
               if (ack) begin
                  pc_d = pc_inc;
                  if (STALL) begin
                     hbuf_d  = IMEM_RDATA;
                     hpc1_d  = pc_inc;
                     state_d = S_HOLD;
                  end else begin
                     ir_d       = IMEM_RDATA;
                     pc1_d      = pc_inc;
                     ir_valid_d = 1'b1;
                  end
               end else if (!STALL) begin
                  ir_d       = NOP_INSTR;
                  ir_valid_d = 1'b0;
               end
            end
            S_HOLD: begin
               if (!STALL) begin
                  ir_d       = hbuf_q;
                  pc1_d      = hpc1_q;
                  ir_valid_d = 1'b1;
                  state_d    = S_REQ;
               end
            end
            S_DRAIN: begin
               if (ack) state_d = S_REQ;
            end
            default: state_d = S_REQ;
         endcase
      end
   end

   // NOTE: state uses non-blocking assignments only; reset is synchronous and sampled on the edge.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         pc1_q      <= '0;
         hpc1_q     <= '0;
         daddr_q    <= '0;
         ir_q       <= NOP_INSTR;
         hbuf_q     <= '0;
         ir_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pc1_q      <= pc1_d;
         hpc1_q     <= hpc1_d;
         daddr_q    <= daddr_d;
         ir_q       <= ir_d;
         hbuf_q     <= hbuf_d;
         ir_valid_q <= ir_valid_d;
      end
   end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage of the RISC pipeline: owns the program counter, issues word reads to instruction memory over a req/ack handshake, and loads the IR/PC_1 pipeline registers consumed directly by `Instruction_decoder`. It handles memory wait states, downstream stalls (one-entry skid buffer) and branch/jump redirects from the execute stage (flush plus discard of in-flight reads). Bubbles are emitted as the all-zero NOP instruction.

## Interface
- PC_WIDTH, 32, program-counter and instruction-address width
- RESET_PC, 0, PC value loaded by reset
- NOP_INSTR, 32'h0000_0000, instruction word driven into IR for bubbles/flushes (opcode 7'b0000000)
- CLK  in  1  rising-edge clock
- RESET  in  1  reset, synchronous, active-high
- STALL  in  1  downstream cannot accept a new IR this cycle; IR/PC_1/IR_VALID hold
- REDIRECT  in  1  taken branch/jump; flush and refetch from REDIRECT_PC
- REDIRECT_PC  in  PC_WIDTH  redirect target
- IMEM_REQ  out  1  read request
- IMEM_ADDR  out  PC_WIDTH  read address; equals PC
- IMEM_ACK  in  1  read data valid this cycle; completes the request
- IMEM_RDATA  in  32  instruction word, valid with IMEM_ACK
- IR  out  32  instruction register to decoder (IR[31:25] = opcode)
- PC_1  out  PC_WIDTH  address of IR instruction + 1
- IR_VALID  out  1  IR holds a real fetched instruction

## Operation
- State machine: REQ, HOLD, DRAIN. All outputs registered except IMEM_REQ/IMEM_ADDR, which decode from state and PC.
- REQ: IMEM_REQ=1, IMEM_ADDR=PC.
  - ACK, no REDIRECT, no STALL: IR<=RDATA, PC_1<=PC+1, IR_VALID<=1, PC<=PC+1, stay REQ.
  - ACK with STALL, no REDIRECT: HBUF<=RDATA, HPC1<=PC+1, PC<=PC+1, go HOLD; IR regs hold.
  - No ACK, no STALL: IR<=NOP_INSTR, IR_VALID<=0 (bubble). No ACK with STALL: hold.
- HOLD: IMEM_REQ=0. When STALL=0: IR<=HBUF, PC_1<=HPC1, IR_VALID<=1, go REQ.
- REDIRECT (any state, priority over STALL and ACK): IR<=NOP_INSTR, IR_VALID<=0, PC<=REDIRECT_PC, HBUF discarded.
  - From REQ without same-cycle ACK: go DRAIN (read in flight).
  - From REQ with same-cycle ACK, or from HOLD or DRAIN-with-ACK: go REQ; RDATA discarded.
- DRAIN: IMEM_REQ=1, IMEM_ADDR=old address (latched DADDR, not PC); on ACK discard RDATA, go REQ. IR = NOP, IR_VALID=0 while draining. A second REDIRECT during DRAIN updates PC only.
- Handshake: once IMEM_REQ rises, REQ and ADDR stay constant until ACK is sampled. Exactly one outstanding read. ACK while IMEM_REQ=0 is ignored.
- Arithmetic: PC+1 modulo 2^PC_WIDTH (all-ones wraps to 0). Word addressing.

## Timing
- Reset (sampled on edge): PC=RESET_PC, state=REQ, IR=NOP_INSTR, PC_1=0, IR_VALID=0, HBUF=0. IMEM_REQ=1 with IMEM_ADDR=RESET_PC in the first cycle after reset.
- RESET during any state, including an un-acked read, aborts it: the late ACK is not tracked, and the memory restarts at the new request.
- Fetch latency: IR valid the edge after ACK is sampled. With ACK tied high, one instruction per cycle, zero bubbles.
- N wait cycles per read give N bubble cycles (IR_VALID=0) when not stalled.
- Redirect penalty: with zero-wait memory, the first target instruction reaches IR 2 edges after REDIRECT is sampled (DRAIN adds outstanding wait cycles).
- STALL release from HOLD: IR updates at the next edge. The new request issues the cycle after.

## Test plan
- Reset, ACK tied 1, RDATA=0x1000_0000|ADDR -> IMEM_ADDR 0,1,2,3 consecutive cycles; IR 0x1000_0000,0x1000_0001,...; PC_1 1,2,3; IR_VALID continuously 1 after first edge.
- ACK delayed 3 cycles at ADDR=0x5 -> ADDR stable at 0x5 for 4 cycles, 3 bubbles (IR=0, IR_VALID=0), then IR=RDATA, PC_1=0x6.
- STALL high across an ACK at ADDR=0x8 -> IR unchanged, IMEM_REQ=0 while STALL, STALL drop -> IR=word@0x8, PC_1=0x9, next ADDR=0x9.
- REDIRECT to 0x40 while read at 0x10 outstanding, ACK 2 cycles later -> IR=NOP/IR_VALID=0 next edge, ADDR holds 0x10 until ACK, data discarded, then ADDR=0x40, IR=word@0x40, PC_1=0x41.
- REDIRECT to 0x20 same cycle as ACK and STALL -> returned word discarded, IR=NOP, next ADDR=0x20; RESET mid-DRAIN -> ADDR=RESET_PC, all outputs at reset values.
- RESET_PC=32'hFFFF_FFFF, ACK tied 1 -> ADDR FFFF_FFFF then 0000_0000; PC_1 0 then 1.
